// File: rtl/spi_slave_burst.sv
// SPI slave (CPHA = 0) that bridges a microcontroller to an on-chip RAM or register file.
// A 2-byte header carries the command and base address, followed by a burst of data words at auto-incrementing addresses.
module spi_slave_burst #(
    parameter int WORD_BYTES = 1,
    parameter int ADDR_W     = 14,
    parameter int CPOL       = 0,
    parameter int RD_LAT     = 1
) (
    input  logic                      i_sys_clk,
    input  logic                      i_rst,
    input  logic                      i_sclk,
    input  logic                      i_ssn,
    input  logic                      i_mosi,
    output logic                      o_miso,
    input  logic [8*WORD_BYTES-1:0]   i_data,
    output logic                      o_rd,
    output logic                      o_wr,
    output logic [ADDR_W-1:0]         o_addr,
    output logic [8*WORD_BYTES-1:0]   o_data,
    output logic                      o_busy
);

    localparam int DW = 8 * WORD_BYTES;
    localparam int BW = $clog2(DW);
    localparam logic SCLK_IDLE = (CPOL != 0);
    localparam logic [BW-1:0] HDR_LAST  = BW'(7);
    localparam logic [BW-1:0] DATA_LAST = BW'(DW - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HDR0 = 2'd1;
    localparam logic [1:0] ST_HDR1 = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    logic [2:0]        sclk_q;
    logic [2:0]        ssn_q;
    logic [1:0]        mosi_q;
    logic              sclk_now;
    logic              sclk_prev;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              ssn_fall;
    logic              ssn_rise;
    logic              mosi_s;
    logic              strobe_ok;

    logic [1:0]        state;
    logic [BW-1:0]     bit_cnt;
    logic [DW-1:0]     rx_sr;
    logic [DW-1:0]     tx_sr;
    logic [DW-1:0]     hold;
    logic [RD_LAT-1:0] rd_pipe;
    logic [5:0]        addr_hi;
    logic [ADDR_W-1:0] nxt_addr;
    logic              is_wr;
    logic              is_rd;
    logic              pend_hdr0;
    logic              pend_hdr1;
    logic              pend_word;
    logic              warm;
    logic              armed;

    // Index 0 is the first synchroniser flop; SCLK and SSN keep a third flop for edge detection.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            sclk_q <= {3{SCLK_IDLE}};
            ssn_q  <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], i_sclk};
            ssn_q  <= {ssn_q[1:0], i_ssn};
            mosi_q <= {mosi_q[0], i_mosi};
        end
    end

    assign sclk_now  = sclk_q[1] ^ SCLK_IDLE;
    assign sclk_prev = sclk_q[2] ^ SCLK_IDLE;
    assign sclk_rise = sclk_now & ~sclk_prev;
    assign sclk_fall = ~sclk_now & sclk_prev;
    assign ssn_fall  = ~ssn_q[1] & ssn_q[2] & armed;
    assign ssn_rise  = ssn_q[1] & ~ssn_q[2];
    assign mosi_s    = mosi_q[1];

    // A strobe is dropped if SSN is already seen rising, so nothing fires once o_busy falls.
    assign strobe_ok = (state != ST_IDLE) && !ssn_q[0] && !ssn_q[1];

    assign o_busy = ~ssn_q[1];
    assign o_miso = (state == ST_DATA && is_rd) ? tx_sr[DW-1] : 1'b0;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            tx_sr     <= '0;
            hold      <= '0;
            rd_pipe   <= '0;
            addr_hi   <= '0;
            nxt_addr  <= '0;
            is_wr     <= 1'b0;
            is_rd     <= 1'b0;
            pend_hdr0 <= 1'b0;
            pend_hdr1 <= 1'b0;
            pend_word <= 1'b0;
            warm      <= 1'b0;
            armed     <= 1'b0;
            o_wr      <= 1'b0;
            o_rd      <= 1'b0;
            o_addr    <= '0;
            o_data    <= '0;
        end else begin
            o_wr      <= 1'b0;
            o_rd      <= 1'b0;
            pend_hdr0 <= 1'b0;
            pend_hdr1 <= 1'b0;
            pend_word <= 1'b0;

            // After reset a frame may only start once SSN has really been sampled high.
            warm <= 1'b1;
            if (warm && ssn_q[0])
                armed <= 1'b1;

            rd_pipe <= (rd_pipe << 1) | RD_LAT'(o_rd);
            if (rd_pipe[RD_LAT-1])
                hold <= i_data;

            // Completed bytes/words are acted on one cycle after the shift that finished them.
            if (pend_hdr0) begin
                is_wr   <= (rx_sr[7:6] == 2'b10);
                is_rd   <= (rx_sr[7:6] == 2'b01);
                addr_hi <= rx_sr[5:0];
            end
            if (pend_hdr1) begin
                if (is_rd && strobe_ok) begin
                    o_rd     <= 1'b1;
                    o_addr   <= ADDR_W'({addr_hi, rx_sr[7:0]});
                    nxt_addr <= ADDR_W'({addr_hi, rx_sr[7:0]}) + ADDR_W'(1);
                end else begin
                    nxt_addr <= ADDR_W'({addr_hi, rx_sr[7:0]});
                end
            end
            if (pend_word && strobe_ok && (is_wr || is_rd)) begin
                o_wr     <= is_wr;
                o_rd     <= is_rd;
                o_addr   <= nxt_addr;
                nxt_addr <= nxt_addr + ADDR_W'(1);
                if (is_wr)
                    o_data <= rx_sr;
            end

            if (ssn_rise) begin
                state <= ST_IDLE;
            end else if (ssn_fall) begin
                state   <= ST_HDR0;
                is_wr   <= 1'b0;
                is_rd   <= 1'b0;
                bit_cnt <= '0;
                // An SCLK edge coinciding with frame start is bit 0 of the header.
                if (sclk_rise) begin
                    rx_sr   <= {rx_sr[DW-2:0], mosi_s};
                    bit_cnt <= BW'(1);
                end
            end else if (state != ST_IDLE) begin
                if (sclk_rise) begin
                    rx_sr <= {rx_sr[DW-2:0], mosi_s};
                    if (state != ST_DATA && bit_cnt == HDR_LAST) begin
                        bit_cnt   <= '0;
                        pend_hdr0 <= (state == ST_HDR0);
                        pend_hdr1 <= (state == ST_HDR1);
                        state     <= (state == ST_HDR0) ? ST_HDR1 : ST_DATA;
                    end else if (state == ST_DATA && bit_cnt == DATA_LAST) begin
                        bit_cnt   <= '0;
                        pend_word <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                // The shift edge at a word boundary loads the prefetched word instead of shifting.
                if (sclk_fall && state == ST_DATA) begin
                    if (bit_cnt == '0)
                        tx_sr <= hold;
                    else
                        tx_sr <= {tx_sr[DW-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_burst.sv
// Directed bench for spi_slave_burst: four instances cover default, 16-bit read, 4-bit address wrap and CPOL = 1.
// Strobes are logged on the falling system-clock edge and compared against hand-computed values.
module tb_spi_slave_burst;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk = 1'b0;
    logic ssn = 1'b1;
    logic mosi = 1'b0;
    logic sclk_inv;

    logic        miso_a, rd_a, wr_a, busy_a;
    logic [13:0] addr_a;
    logic [7:0]  data_a;

    logic        miso_b, rd_b, wr_b, busy_b;
    logic [13:0] addr_b;
    logic [15:0] data_b;
    logic [15:0] din_b = '0;
    logic [15:0] stage_b = '0;

    logic        miso_c, rd_c, wr_c, busy_c;
    logic [3:0]  addr_c;
    logic [7:0]  data_c;

    logic        miso_d, rd_d, wr_d, busy_d;
    logic [13:0] addr_d;
    logic [7:0]  data_d;

    logic [21:0] wr_a_q[$];
    logic [21:0] wr_d_q[$];
    logic [11:0] wr_c_q[$];
    logic [13:0] rd_b_q[$];
    int rd_a_n = 0;
    int rd_d_n = 0;
    int wr_b_n = 0;
    int viol_n = 0;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] miso_b_acc;
    logic        miso_a_or;

    assign sclk_inv = ~sclk;

    always #5 clk = ~clk;

    spi_slave_burst u_a (
        .i_sys_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_ssn(ssn), .i_mosi(mosi),
        .o_miso(miso_a), .i_data(8'h00), .o_rd(rd_a), .o_wr(wr_a),
        .o_addr(addr_a), .o_data(data_a), .o_busy(busy_a)
    );

    spi_slave_burst #(.WORD_BYTES(2), .RD_LAT(2)) u_b (
        .i_sys_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_ssn(ssn), .i_mosi(mosi),
        .o_miso(miso_b), .i_data(din_b), .o_rd(rd_b), .o_wr(wr_b),
        .o_addr(addr_b), .o_data(data_b), .o_busy(busy_b)
    );

    spi_slave_burst #(.ADDR_W(4)) u_c (
        .i_sys_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_ssn(ssn), .i_mosi(mosi),
        .o_miso(miso_c), .i_data(8'h00), .o_rd(rd_c), .o_wr(wr_c),
        .o_addr(addr_c), .o_data(data_c), .o_busy(busy_c)
    );

    spi_slave_burst #(.CPOL(1)) u_d (
        .i_sys_clk(clk), .i_rst(rst), .i_sclk(sclk_inv), .i_ssn(ssn), .i_mosi(mosi),
        .o_miso(miso_d), .i_data(8'h00), .o_rd(rd_d), .o_wr(wr_d),
        .o_addr(addr_d), .o_data(data_d), .o_busy(busy_d)
    );

    function automatic logic [15:0] mem_rd(input logic [13:0] a);
        case (a)
            14'h020: mem_rd = 16'h1234;
            14'h021: mem_rd = 16'hBEEF;
            default: mem_rd = 16'hDEAD;
        endcase
    endfunction

    // Memory for u_b: data is valid two cycles after the read strobe.
    always @(posedge clk) begin
        if (rd_b)
            stage_b <= mem_rd(addr_b);
        din_b <= stage_b;
    end

    always @(negedge clk) begin
        if (wr_a) wr_a_q.push_back({addr_a, data_a});
        if (rd_a) rd_a_n++;
        if (rd_b) rd_b_q.push_back(addr_b);
        if (wr_b) wr_b_n++;
        if (wr_c) wr_c_q.push_back({addr_c, data_c});
        if (wr_d) wr_d_q.push_back({addr_d, data_d});
        if (rd_d) rd_d_n++;
        if ((wr_a && rd_a) || ((wr_a || rd_a) && !busy_a)) viol_n++;
        if ((wr_b && rd_b) || ((wr_b || rd_b) && !busy_b)) viol_n++;
        if ((wr_c && rd_c) || ((wr_c || rd_c) && !busy_c)) viol_n++;
        if ((wr_d && rd_d) || ((wr_d || rd_d) && !busy_d)) viol_n++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        repeat (HALF) @(negedge clk);
        miso_b_acc = {miso_b_acc[30:0], miso_b};
        miso_a_or  = miso_a_or | miso_a;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--)
            spi_bit(v[i]);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        ssn = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    initial begin
        int base_a;
        int base_c;
        int base_d;
        int base_b;
        int rd_base;
        int wrb_base;
        int rdd_base;

        miso_b_acc = '0;
        miso_a_or  = 1'b0;

        // Reset values
        repeat (4) @(negedge clk);
        check("rst_wr", wr_a, 1'b0);
        check("rst_rd", rd_a, 1'b0);
        check("rst_addr", addr_a, 14'h0);
        check("rst_data", data_a, 8'h0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_miso", miso_a, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Write burst, replayed on the CPOL = 1 instance through the inverted SCLK
        base_a = wr_a_q.size();
        base_d = wr_d_q.size();
        rd_base = rd_a_n;
        rdd_base = rd_d_n;
        ssn = 1'b0;
        @(negedge clk);
        check("busy_lag1", busy_a, 1'b0);
        @(negedge clk);
        check("busy_lag2", busy_a, 1'b1);
        spi_byte(8'h80); spi_byte(8'h10);
        spi_byte(8'hA5); spi_byte(8'h5A); spi_byte(8'hFF);
        frame_end();
        check("wr_count", wr_a_q.size() - base_a, 3);
        check("wr0", wr_a_q[base_a],     {14'h010, 8'hA5});
        check("wr1", wr_a_q[base_a + 1], {14'h011, 8'h5A});
        check("wr2", wr_a_q[base_a + 2], {14'h012, 8'hFF});
        check("wr_no_rd", rd_a_n - rd_base, 0);
        check("cpol1_count", wr_d_q.size() - base_d, 3);
        check("cpol1_wr0", wr_d_q[base_d],     {14'h010, 8'hA5});
        check("cpol1_wr1", wr_d_q[base_d + 1], {14'h011, 8'h5A});
        check("cpol1_wr2", wr_d_q[base_d + 2], {14'h012, 8'hFF});
        check("cpol1_no_rd", rd_d_n - rdd_base, 0);
        check("busy_end", busy_a, 1'b0);

        // Read burst on the 16-bit, RD_LAT = 2 instance
        base_b = rd_b_q.size();
        wrb_base = wr_b_n;
        ssn = 1'b0;
        spi_byte(8'h40); spi_byte(8'h20);
        miso_b_acc = '0;
        spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h00);
        frame_end();
        check("rd_word0", miso_b_acc[31:16], 16'h1234);
        check("rd_word1", miso_b_acc[15:0], 16'hBEEF);
        check("rd_count", rd_b_q.size() - base_b, 3);
        check("rd_addr0", rd_b_q[base_b],     14'h020);
        check("rd_addr1", rd_b_q[base_b + 1], 14'h021);
        check("rd_addr2", rd_b_q[base_b + 2], 14'h022);
        check("rd_no_wr", wr_b_n - wrb_base, 0);

        // Address wrap on the 4-bit address instance
        base_c = wr_c_q.size();
        ssn = 1'b0;
        spi_byte(8'h80); spi_byte(8'h0E);
        spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33); spi_byte(8'h44);
        frame_end();
        check("wrap_count", wr_c_q.size() - base_c, 4);
        check("wrap0", wr_c_q[base_c],     {4'hE, 8'h11});
        check("wrap1", wr_c_q[base_c + 1], {4'hF, 8'h22});
        check("wrap2", wr_c_q[base_c + 2], {4'h0, 8'h33});
        check("wrap3", wr_c_q[base_c + 3], {4'h1, 8'h44});

        // Abort after 5 data bits, then a normal frame
        base_a = wr_a_q.size();
        ssn = 1'b0;
        spi_byte(8'h80); spi_byte(8'h10);
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        frame_end();
        check("abort_no_wr", wr_a_q.size() - base_a, 0);
        check("abort_busy", busy_a, 1'b0);
        ssn = 1'b0;
        spi_byte(8'h80); spi_byte(8'h33); spi_byte(8'h3C);
        frame_end();
        check("after_abort_count", wr_a_q.size() - base_a, 1);
        check("after_abort_wr", wr_a_q[base_a], {14'h033, 8'h3C});

        // No-op frame
        base_a = wr_a_q.size();
        rd_base = rd_a_n;
        miso_a_or = 1'b0;
        ssn = 1'b0;
        spi_byte(8'hC0); spi_byte(8'h00); spi_byte(8'hAA); spi_byte(8'h55);
        frame_end();
        check("noop_no_wr", wr_a_q.size() - base_a, 0);
        check("noop_no_rd", rd_a_n - rd_base, 0);
        check("noop_miso", miso_a_or, 1'b0);

        // Reset pulsed mid-byte, then a normal frame
        base_a = wr_a_q.size();
        ssn = 1'b0;
        spi_byte(8'h80); spi_byte(8'h10);
        spi_bit(1'b1); spi_bit(1'b0); spi_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_wr", wr_a, 1'b0);
        check("mid_rst_rd", rd_a, 1'b0);
        check("mid_rst_addr", addr_a, 14'h0);
        check("mid_rst_data", data_a, 8'h0);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_miso", miso_a, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        frame_end();
        check("mid_rst_no_wr", wr_a_q.size() - base_a, 0);
        ssn = 1'b0;
        spi_byte(8'h80); spi_byte(8'h44); spi_byte(8'h96);
        frame_end();
        check("after_rst_count", wr_a_q.size() - base_a, 1);
        check("after_rst_wr", wr_a_q[base_a], {14'h044, 8'h96});

        check("strobe_rules", viol_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_burst.md
# spi_slave_burst

Parametrised SPI slave that bridges an external microcontroller to an on-chip RAM or register file in the modem datapath. It is the successor to the fixed 8-bit, 10-bit-address SPI slave. Word width, address width, clock polarity and read latency are parameters. It adds explicit write, read and no-op commands, read prefetch with a holding buffer, and abort-safe partial-word handling. Each frame is a 2-byte header followed by a burst of data words at auto-incrementing addresses.

## Interface
- WORD_BYTES, 1, bytes per data word (1, 2 or 4); DW = 8*WORD_BYTES
- ADDR_W, 14, address width (1..14); header address is truncated to ADDR_W bits
- CPOL, 0, SCLK idle level; 1 means SCLK is inverted after synchronisation (CPHA = 0 only)
- RD_LAT, 1, i_sys_clk cycles from o_rd to valid i_data (1..4)

Ports:
- i_sys_clk  in  1  system clock, the only clock
- i_rst  in  1  synchronous, active-high reset
- i_sclk  in  1  SPI clock, asynchronous
- i_ssn  in  1  SPI chip select, active low, asynchronous
- i_mosi  in  1  SPI data in, asynchronous
- o_miso  out  1  SPI data out, MSB first
- i_data  in  DW  read data from memory, valid RD_LAT cycles after o_rd
- o_rd  out  1  one-cycle read strobe
- o_wr  out  1  one-cycle write strobe
- o_addr  out  ADDR_W  address qualified by o_wr or o_rd
- o_data  out  DW  write data, qualified by o_wr
- o_busy  out  1  synchronised chip select is active

## Operation
- Inputs pass through 2 flops into i_sys_clk; SCLK and SSN have a third flop for edge detection.
- Reset drives all synchronisers to idle: SSN = 1, SCLK = CPOL.
- Sample edge is synced SCLK rising (after CPOL inversion); shift edge is falling.
- Falling edge of synced SSN starts a frame and clears the bit counter, word counter and state.
- State machine: IDLE -> HDR0 -> HDR1 -> DATA -> IDLE.
  - Any SSN rising edge returns to IDLE. A partial word is discarded: no o_wr, no o_rd.
  - HDR0: byte bits [7:6] give the command. 2'b10 = write, 2'b01 = read, 2'b00 and 2'b11 = no-op. Bits [5:0] are address bits [13:8].
  - HDR1: byte gives address bits [7:0]. The base address A is latched at the end of HDR1.
  - DATA: words of DW bits, MSB first. Word k uses address (A + k) mod 2^ADDR_W, so the address wraps silently.
- Write: on completion of word k, o_wr pulses for 1 cycle with o_data = word k and o_addr = A + k.
- Read prefetch:
  - At the end of HDR1, and again when each data word completes, o_rd pulses for 1 cycle at the next address: A first, then A + k + 1.
  - i_data is captured into a DW-bit holding register exactly RD_LAT cycles later.
  - On the next shift edge the holding register moves into the MISO shift register.
  - The final prefetch of a frame is a harmless extra read.
- No-op: no strobes are issued; o_miso = 0.
- o_miso drives shift register MSB during DATA on reads, and 0 at all other times.

## Timing
- Reset values: o_miso = 0, o_rd = 0, o_wr = 0, o_data = 0, o_addr = 0, o_busy = 0, state IDLE.
- Reset asserted mid-frame aborts the frame with no strobe. The block ignores the remainder until a fresh SSN falling edge.
- Let cycle N be the first i_sys_clk edge that samples raw SCLK at its sampling level.
  - The bit shifts in at N+2.
  - For the last bit of a word, o_wr or o_rd asserts at N+3.
- o_busy follows raw SSN with 2 cycles of delay.
- SCLK high and low times must each be at least RD_LAT + 4 i_sys_clk cycles; this lets the prefetch land before the next shift edge.
- SSN falling and SCLK rising arriving in the same synced cycle: the frame start wins, and that edge is counted as bit 0.
- o_wr and o_rd never assert in the same cycle, and never assert while o_busy = 0.

## Test plan
- Write burst, WORD_BYTES = 1: header 0x80 0x10, data 0xA5 0x5A 0xFF -> three o_wr pulses at addr 0x010/0x011/0x012 with o_data 0xA5/0x5A/0xFF; o_rd never asserts.
- Read burst, WORD_BYTES = 2, RD_LAT = 2: header 0x40 0x20, memory model returns 0x1234 then 0xBEEF -> MISO stream 0x1234 0xBEEF; o_rd at addr 0x020, 0x021, 0x022.
- Wrap, ADDR_W = 4: write header 0x80 0x0E, four data bytes -> o_addr sequence 0xE, 0xF, 0x0, 0x1.
- Abort: write header plus 5 bits of a data byte, then SSN high -> no o_wr, state IDLE; the next frame behaves normally.
- No-op header 0xC0 0x00 followed by 2 bytes -> no o_wr and no o_rd; o_miso held 0.
- CPOL = 1 with an inverted SCLK stream replaying scenario 1 -> identical strobes. i_rst pulsed mid-byte -> all outputs return to reset values the next cycle, with no strobe.
